// File: rtl/skolem_pkg.sv
// Shared types and Skolem witness / invertibility helpers for the urem-x family.
// Helpers work at MAXW bits; callers pass the live width and truncate.
package skolem_pkg;

    localparam int MAXW = 32;

    typedef enum logic {
        UGT = 1'b0,
        ULT = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        CHECK,
        DONE
    } state_e;

    function automatic logic [MAXW-1:0] wmask(int unsigned w);
        logic [MAXW-1:0] m;
        m = '1;
        if (w < MAXW) m = m >> (MAXW - w);
        return m;
    endfunction

    function automatic logic [MAXW-1:0] wit_urem_x(
        op_e             op,
        logic [MAXW-1:0] s,
        int unsigned     w
    );
        logic [MAXW-1:0] x;
        x = ~(-s) & wmask(w);
        if (op == ULT) x = '0;
        return x;
    endfunction

    function automatic logic ic_urem_x(
        op_e             op,
        logic [MAXW-1:0] s,
        logic [MAXW-1:0] t,
        int unsigned     w
    );
        logic r;
        if (op == ULT) r = (t != '0);
        else           r = (t < wit_urem_x(UGT, s, w));
        return r;
    endfunction

endpackage

// File: rtl/urem_serial.sv
// Restoring serial unsigned remainder, one quotient bit per cycle, MSB first.
// A zero divisor never subtracts, so the remainder ends equal to the dividend.
module urem_serial
    import skolem_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W);

    logic [W:0]    rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    logic [W+1:0]  sh;
    logic [W+1:0]  diff;
    logic          borrow;
    logic [W:0]    rem_d;

    always_comb begin
        sh     = {rem_q, quo_q[W-1]};
        diff   = sh - {2'b00, dvs_q};
        borrow = diff[W+1];
        rem_d  = borrow ? sh[W:0] : diff[W:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= '0;
                quo_q  <= dividend;
                dvs_q  <= divisor;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_d;
                quo_q <= {quo_q[W-2:0], ~borrow};
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(W-1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done      = done_q;
    assign remainder = rem_q[W-1:0];

endmodule

// File: rtl/skolem_urem_cmp_seq.sv
// Sequential Skolem witness for (x urem s) >u t / <u t, unknown x in dividend.
// Define SKOLEM_URM_SELFCHECK_EN to add the serial remainder self-check.
module skolem_urem_cmp_seq
    import skolem_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_op,
    input  logic [W-1:0] in_s,
    input  logic [W-1:0] in_t,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic         out_ic,
    output logic         out_chk_ok
);

    state_e       state_q, state_d;
    op_e          op_q;
    logic [W-1:0] s_q, t_q, x_q;
    logic         ic_q;
    logic [W-1:0] x_d;
    logic         ic_d;
    logic         out_valid_q, out_ic_q, out_chk_q;
    logic [W-1:0] out_x_q;
    logic         cap;
    logic         chk_d;
    logic         chk_last;

    assign x_d  = W'(wit_urem_x(op_q, MAXW'(s_q), W));
    assign ic_d = ic_urem_x(op_q, MAXW'(s_q), MAXW'(t_q), W);

`ifdef SKOLEM_URM_SELFCHECK_EN
    localparam int CW = $clog2(W);

    logic [CW-1:0] cnt_q;
    logic          div_done;
    logic [W-1:0]  rem;
    logic          rel;

    urem_serial #(.W(W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (state_q == CALC),
        .dividend (x_d),
        .divisor  (s_q),
        .done     (div_done),
        .remainder(rem)
    );

    assign rel      = (op_q == UGT) ? (rem > t_q) : (rem < t_q);
    assign chk_d    = (rel == ic_q);
    assign chk_last = (cnt_q == CW'(W-1));
    assign cap      = (state_q == DONE) && !out_valid_q && div_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt_q <= '0;
        else if (state_q == CALC)  cnt_q <= '0;
        else if (state_q == CHECK) cnt_q <= cnt_q + 1'b1;
    end
`else
    assign chk_d    = 1'b1;
    assign chk_last = 1'b1;
    assign cap      = (state_q == DONE) && !out_valid_q;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (in_valid) state_d = CALC;
`ifdef SKOLEM_URM_SELFCHECK_EN
            CALC:  state_d = CHECK;
`else
            CALC:  state_d = DONE;
`endif
            CHECK: if (chk_last) state_d = DONE;
            DONE:  if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // First DONE cycle latches the result so the output regs stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= UGT;
            s_q         <= '0;
            t_q         <= '0;
            x_q         <= '0;
            ic_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_ic_q    <= 1'b0;
            out_chk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                op_q <= op_e'(in_op);
                s_q  <= in_s;
                t_q  <= in_t;
            end
            if (state_q == CALC) begin
                x_q  <= x_d;
                ic_q <= ic_d;
            end
            if (cap) begin
                out_valid_q <= 1'b1;
                out_x_q     <= x_q;
                out_ic_q    <= ic_q;
                out_chk_q   <= chk_d;
            end else if (state_q == DONE && out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
                out_chk_q   <= 1'b0;
            end
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_ic     = out_ic_q;
    assign out_chk_ok = out_chk_q;

endmodule

// File: tb/tb_skolem_urem_cmp_seq.sv
// Directed table, corner sequences and exhaustive sweep for skolem_urem_cmp_seq.
module tb_skolem_urem_cmp_seq;

    localparam int W = 4;
`ifdef SKOLEM_URM_SELFCHECK_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_op;
    logic [W-1:0] in_s;
    logic [W-1:0] in_t;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_x;
    logic         out_ic;
    logic         out_chk_ok;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    skolem_urem_cmp_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_s      (in_s),
        .in_t      (in_t),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_ic    (out_ic),
        .out_chk_ok(out_chk_ok)
    );

    typedef struct {
        logic       op;
        logic [3:0] s;
        logic [3:0] t;
        logic [3:0] x;
        logic       ic;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic send(input logic op, input logic [3:0] s, input logic [3:0] t);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_s     = s;
        in_t     = t;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = ~op;
        in_s     = ~s;
        in_t     = ~t;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_next", int'(in_ready), 1);
        check("valid_drop", int'(out_valid), 0);
    endtask

    task automatic run_one(input string tag, input logic op, input logic [3:0] s,
                           input logic [3:0] t, input logic [3:0] ex, input logic ei);
        int lat;
        send(op, s, t);
        wait_out(lat);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_x"}, int'(out_x), int'(ex));
        check({tag, "_ic"}, int'(out_ic), int'(ei));
        check({tag, "_chk"}, int'(out_chk_ok), 1);
        consume();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         lat;
        logic       stale;
        logic [3:0] maxr, ex;
        logic       ei;

        vt[0] = '{1'b0, 4'd5, 4'd2,  4'd4,  1'b1};
        vt[1] = '{1'b0, 4'd0, 4'd14, 4'd15, 1'b1};
        vt[2] = '{1'b0, 4'd0, 4'd15, 4'd15, 1'b0};
        vt[3] = '{1'b0, 4'd1, 4'd0,  4'd0,  1'b0};
        vt[4] = '{1'b1, 4'd7, 4'd0,  4'd0,  1'b0};
        vt[5] = '{1'b1, 4'd7, 4'd3,  4'd0,  1'b1};
        vt[6] = '{1'b0, 4'd8, 4'd7,  4'd7,  1'b0};
        vt[7] = '{1'b1, 4'd0, 4'd5,  4'd0,  1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_s      = '0;
        in_t      = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_x", int'(out_x), 0);
        check("rst_out_ic", int'(out_ic), 0);
        check("rst_out_chk", int'(out_chk_ok), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_one($sformatf("vec%0d", i), vt[i].op, vt[i].s, vt[i].t, vt[i].x, vt[i].ic);

        // Backpressure: result must hold while out_ready stays low.
        send(1'b0, 4'd3, 4'd1);
        wait_out(lat);
        check("bp_lat", lat, LAT);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", int'(out_valid), 1);
            check("bp_x", int'(out_x), 2);
            check("bp_ic", int'(out_ic), 1);
            check("bp_in_ready", int'(in_ready), 0);
        end
        consume();

        // Reset in the middle of a request drops it entirely.
        send(1'b0, 4'd5, 4'd2);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        stale = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("mid_rst_no_stale", int'(stale), 0);
        run_one("post_rst", 1'b1, 4'd7, 4'd3, 4'd0, 1'b1);

        // Largest attainable remainder is s-1, or all-ones for s == 0.
        for (int op = 0; op < 2; op++)
            for (int s = 0; s < 16; s++)
                for (int t = 0; t < 16; t++) begin
                    maxr = (s == 0) ? 4'hF : 4'(s - 1);
                    ex   = (op == 1) ? 4'd0 : maxr;
                    ei   = (op == 1) ? (t != 0) : (4'(t) < maxr);
                    run_one("sweep", op[0], 4'(s), 4'(t), ex, ei);
                end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
